// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: shared pipelined FP16 multiplier array with round-robin/lock arbitration
module fp16_mult_wrapper #(
  parameter int M_LAT = 6
) (
  input  logic        clk,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        valid_out,
  output logic [15:0] p
);
  logic [21:0] m;
  logic [20:0] mn;
  logic [10:0] mr;
  logic rnd, s, za, zb, ia, ib, nan;
  int e;
  logic [15:0] f;
  logic [M_LAT-1:0] pv;
  logic [15:0] pp [M_LAT];
  // product with round-to-nearest-even; subnormal inputs and results flush to zero
  always_comb begin
    m = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    mn = m[21] ? m[20:0] : {m[19:0], 1'b0};
    rnd = mn[10] & ((|mn[9:0]) | mn[11]);
    mr = {1'b0, mn[20:11]} + {10'b0, rnd};
    e = int'(a[14:10]) + int'(b[14:10]) - 15 + int'(m[21]) + int'(mr[10]);
    s = a[15] ^ b[15];
    za = a[14:10] == 5'd0;
    zb = b[14:10] == 5'd0;
    ia = a[14:10] == 5'h1f;
    ib = b[14:10] == 5'h1f;
    nan = (ia && a[9:0] != 10'd0) || (ib && b[9:0] != 10'd0) || (ia && zb) || (ib && za);
    f = nan ? 16'h7e00 :
        (ia || ib || e >= 31) ? {s, 5'h1f, 10'h0} :
        (za || zb || e <= 0) ? {s, 15'h0} : {s, e[4:0], mr[9:0]};
  end
  // fixed-latency delay line, deliberately without reset
  always_ff @(posedge clk) begin
    pv[0] <= valid_in;
    pp[0] <= f;
    for (int j = 1; j < M_LAT; j++) begin
      pv[j] <= pv[j-1];
      pp[j] <= pp[j-1];
    end
  end
  assign valid_out = pv[M_LAT-1];
  assign p = pp[M_LAT-1];
endmodule

module fp16_mul_arbiter #(
  parameter int NREQ = 3,
  parameter int LANES = 16,
  parameter int DW = 16,
  parameter int TW = 10,
  parameter int M_LAT = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_lock,
  input  logic [NREQ*LANES*DW-1:0]  req_a,
  input  logic [NREQ*LANES*DW-1:0]  req_b,
  input  logic [NREQ*LANES-1:0]     req_lane_en,
  input  logic [NREQ*TW-1:0]        req_tag,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [LANES*DW-1:0]       rsp_data,
  output logic [LANES-1:0]          rsp_lane_en,
  output logic [TW-1:0]             rsp_tag,
  output logic                      busy,
  output logic                      err
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(M_LAT + 2);
  localparam logic [0:0] RUN = 1'b0, WARM = 1'b1;
  logic [IW-1:0] ptr, own, gid;
  logic hold, lk, gnt, vin, lane0_vout, unused_vo;
  logic [0:0] st;
  logic [CW-1:0] cnt;
  logic [DW-1:0] la [LANES];
  logic [DW-1:0] lb [LANES];
  logic [DW-1:0] pr [LANES];
  logic [LANES-1:0] vo;
  logic [M_LAT:0] tv;
  logic [IW-1:0] tid [M_LAT+1];
  logic [TW-1:0] ttag [M_LAT+1];
  logic [LANES-1:0] ten [M_LAT+1];
  assign lk = hold & req_lock[own];
  // locked owner keeps the slot (bubbles included); otherwise nearest valid after ptr wins
  always_comb begin
    gid = ptr;
    gnt = 1'b0;
    if (lk) begin
      gid = own;
      gnt = req_valid[own];
    end else
      for (int i = NREQ; i >= 1; i--)
        if (req_valid[(int'(ptr) + i) % NREQ]) begin
          gid = IW'((int'(ptr) + i) % NREQ);
          gnt = 1'b1;
        end
  end
  assign req_ready = {{(NREQ-1){1'b0}}, gnt} << gid;
  // ownership and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= IW'(NREQ - 1);
      own <= '0;
      hold <= 1'b0;
    end else begin
      if (gnt) ptr <= gid;
      if (lk | gnt) own <= gid;
      hold <= (lk | gnt) & req_lock[gid];
    end
  end
  // lane input registers; disabled lanes are zeroed
  always_ff @(posedge clk) begin
    vin <= rst ? 1'b0 : gnt;
    if (gnt)
      for (int k = 0; k < LANES; k++) begin
        la[k] <= req_lane_en[int'(gid)*LANES+k] ? req_a[(int'(gid)*LANES+k)*DW +: DW] : '0;
        lb[k] <= req_lane_en[int'(gid)*LANES+k] ? req_b[(int'(gid)*LANES+k)*DW +: DW] : '0;
      end
  end
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fp16_mult_wrapper #(.M_LAT(M_LAT)) u_mul (
      .clk(clk), .valid_in(vin), .a(la[k]), .b(lb[k]), .valid_out(vo[k]), .p(pr[k])
    );
    assign rsp_data[k*DW +: DW] = (tv[M_LAT] & ten[M_LAT][k]) ? pr[k] : '0;
  end
  assign lane0_vout = vo[0];
  assign unused_vo = ^vo;
  // tracking pipe runs beside the multipliers; only its valid bits are reset
  always_ff @(posedge clk) begin
    tv <= rst ? '0 : {tv[M_LAT-1:0], gnt};
    tid[0] <= gid;
    ttag[0] <= req_tag[int'(gid)*TW +: TW];
    ten[0] <= req_lane_en[int'(gid)*LANES +: LANES];
    for (int j = 1; j <= M_LAT; j++) begin
      tid[j] <= tid[j-1];
      ttag[j] <= ttag[j-1];
      ten[j] <= ten[j-1];
    end
  end
  assign rsp_valid = {{(NREQ-1){1'b0}}, tv[M_LAT]} << tid[M_LAT];
  assign rsp_tag = tv[M_LAT] ? ttag[M_LAT] : '0;
  assign rsp_lane_en = tv[M_LAT] ? ten[M_LAT] : '0;
  assign busy = |tv;
  // WARM masks the alignment check until unreset wrapper state has flushed
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= WARM;
      cnt <= CW'(M_LAT + 1);
      err <= 1'b0;
    end else begin
      if (st == WARM) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) st <= RUN;
      end
      err <= err | (st == RUN && lane0_vout != tv[M_LAT]);
    end
  end
endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb_fp16_mul_arbiter: table vectors, directed arbitration sequences and random traffic vs a real-valued model
module tb_fp16_mul_arbiter;
  localparam int NREQ = 3, LANES = 16, DW = 16, TW = 10, M_LAT = 6;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_lock = '0, req_ready, rsp_valid;
  logic [NREQ*LANES*DW-1:0] req_a = '0, req_b = '0;
  logic [NREQ*LANES-1:0] req_lane_en = '0;
  logic [NREQ*TW-1:0] req_tag = '0;
  logic [LANES*DW-1:0] rsp_data;
  logic [LANES-1:0] rsp_lane_en;
  logic [TW-1:0] rsp_tag;
  logic busy, err;

  fp16_mul_arbiter #(.NREQ(NREQ), .LANES(LANES), .DW(DW), .TW(TW), .M_LAT(M_LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_a(req_a), .req_b(req_b), .req_lane_en(req_lane_en), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_lane_en(rsp_lane_en), .rsp_tag(rsp_tag),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int id; logic [TW-1:0] tag; logic [LANES-1:0] en; logic [LANES*DW-1:0] data; } op_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic [15:0] en; logic [15:0] p; } vec_t;

  int checks = 0, errors = 0, cyc = 0;
  bit exp_err = 1'b0;
  op_t q[$], gq[$], rq[$];
  op_t e, o;
  int m_last = NREQ - 1, m_own = -1, eg, nown;
  bit m_hold = 1'b0;
  vec_t tbl[13];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // exact real-valued reference: decode, multiply, renormalise, round half to even
  function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic s;
    bit za, zb, ia, ib;
    real p, x, fr;
    int ex, f;
    s = a[15] ^ b[15];
    za = a[14:10] == 0; zb = b[14:10] == 0;
    ia = a[14:10] == 31; ib = b[14:10] == 31;
    if ((ia && a[9:0] != 0) || (ib && b[9:0] != 0) || (ia && zb) || (ib && za)) return 16'h7e00;
    if (ia || ib) return {s, 15'h7c00};
    if (za || zb) return {s, 15'h0};
    p = (1.0 + a[9:0] / 1024.0) * (1.0 + b[9:0] / 1024.0);
    ex = int'(a[14:10]) + int'(b[14:10]) - 30;
    while (p >= 2.0) begin p = p / 2.0; ex++; end
    x = p * 1024.0;
    f = int'($floor(x));
    fr = x - f;
    if (fr > 0.5 || (fr == 0.5 && f % 2 == 1)) f++;
    if (f == 2048) begin f = 1024; ex++; end
    if (ex > 15) return {s, 15'h7c00};
    if (ex < -14) return {s, 15'h0};
    return {s, 5'(ex + 15), 10'(f - 1024)};
  endfunction

  // cycle monitor: arbitration model, response scoreboard, busy and err
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_last = NREQ - 1;
      m_hold = 1'b0;
      m_own = -1;
    end else begin
      chk("busy", 256'(busy), 256'(q.size() != 0));
      chk("err", 256'(err), 256'(exp_err));
      eg = -1;
      if (m_hold && req_lock[m_own]) begin
        nown = m_own;
        if (req_valid[m_own]) eg = m_own;
      end else begin
        for (int i = 1; i <= NREQ && eg < 0; i++)
          if (req_valid[(m_last + i) % NREQ]) eg = (m_last + i) % NREQ;
        nown = eg;
      end
      chk("grant", 256'(req_ready), eg >= 0 ? 256'(1) << eg : 256'(0));
      if (eg >= 0) begin
        m_last = eg;
        e.due = cyc + M_LAT + 1;
        e.id = eg;
        e.tag = req_tag[eg*TW +: TW];
        e.en = req_lane_en[eg*LANES +: LANES];
        for (int k = 0; k < LANES; k++)
          e.data[k*DW +: DW] = e.en[k] ? ref_mul(req_a[(eg*LANES+k)*DW +: DW], req_b[(eg*LANES+k)*DW +: DW]) : 16'h0;
        q.push_back(e);
      end
      m_hold = nown >= 0 && req_lock[nown];
      m_own = nown;
      for (int r = 0; r < NREQ; r++)
        if (req_ready[r] && req_valid[r]) begin o.due = cyc; o.id = r; gq.push_back(o); end
      if (q.size() != 0 && q[0].due == cyc) begin
        chk("rsp_valid", 256'(rsp_valid), 256'(1) << q[0].id);
        chk("rsp_tag", 256'(rsp_tag), 256'(q[0].tag));
        chk("rsp_lane_en", 256'(rsp_lane_en), 256'(q[0].en));
        chk("rsp_data", rsp_data, q[0].data);
        void'(q.pop_front());
      end else
        chk("rsp_idle", 256'({rsp_valid, rsp_tag, rsp_lane_en}) | rsp_data, 256'(0));
      for (int r = 0; r < NREQ; r++)
        if (rsp_valid[r]) begin
          o.due = cyc; o.id = r; o.tag = rsp_tag; o.en = rsp_lane_en; o.data = rsp_data;
          rq.push_back(o);
        end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic v, input logic l, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] en, input logic [9:0] tag);
    req_valid[r] = v;
    req_lock[r] = l;
    req_lane_en[r*LANES +: LANES] = en;
    req_tag[r*TW +: TW] = tag;
    for (int k = 0; k < LANES; k++) begin
      req_a[(r*LANES+k)*DW +: DW] = a;
      req_b[(r*LANES+k)*DW +: DW] = b;
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    exp_err = 1'b0;
    tick(2);
    rst = 1'b0;
    gq.delete();
    rq.delete();
  endtask

  initial begin
    tbl[0]  = '{16'h4000, 16'h4200, 16'hffff, 16'h4600};
    tbl[1]  = '{16'h3c00, 16'h3c00, 16'h000f, 16'h3c00};
    tbl[2]  = '{16'h7bff, 16'h4000, 16'hffff, 16'h7c00};
    tbl[3]  = '{16'h7c00, 16'h0000, 16'hffff, 16'h7e00};
    tbl[4]  = '{16'h0400, 16'h0400, 16'hffff, 16'h0000};
    tbl[5]  = '{16'h3c01, 16'h3c01, 16'hffff, 16'h3c02};
    tbl[6]  = '{16'h3555, 16'h4200, 16'hffff, 16'h3c00};
    tbl[7]  = '{16'hbe00, 16'h4000, 16'h00f0, 16'hc200};
    tbl[8]  = '{16'h8000, 16'h4500, 16'hffff, 16'h8000};
    tbl[9]  = '{16'h7e00, 16'h3c00, 16'hffff, 16'h7e00};
    tbl[10] = '{16'h0001, 16'h7bff, 16'hffff, 16'h0000};
    tbl[11] = '{16'hfc00, 16'h4000, 16'hffff, 16'hfc00};
    tbl[12] = '{16'h3800, 16'h0400, 16'hffff, 16'h0000};

    reset_dut();
    chk("reset_rsp", 256'({rsp_valid, rsp_tag, rsp_lane_en, busy, err}) | rsp_data, 256'(0));
    chk("reset_ready_idle", 256'(req_ready), 256'(0));

    // single request straight out of reset
    set_req(1, 1'b1, 1'b0, 16'h4000, 16'h4200, 16'hffff, 10'h05a);
    tick(1);
    req_valid = '0;
    tick(10);
    chk("single_grants", 256'(gq.size()), 256'(1));
    chk("single_rsps", 256'(rq.size()), 256'(1));
    chk("single_latency", 256'(rq[0].due - gq[0].due), 256'(7));
    chk("single_valid", 256'(1) << rq[0].id, 256'(3'b010));
    chk("single_tag", 256'(rq[0].tag), 256'(10'h05a));
    chk("single_data", rq[0].data, {16{16'h4600}});

    // fairness, no lock
    reset_dut();
    for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, 1'b0, 16'h3c00, 16'h4000 + 16'(r), 16'hffff, 10'(r));
    tick(9);
    req_valid = '0;
    tick(10);
    chk("fair_grants", 256'(gq.size()), 256'(9));
    chk("fair_rsps", 256'(rq.size()), 256'(9));
    for (int i = 0; i < 9; i++) begin
      chk("fair_grant_id", 256'(gq[i].id), 256'(i % 3));
      chk("fair_grant_cyc", 256'(gq[i].due - gq[0].due), 256'(i));
      chk("fair_rsp_id", 256'(rq[i].id), 256'(i % 3));
      chk("fair_rsp_cyc", 256'(rq[i].due - gq[0].due), 256'(7 + i));
    end

    // lock with a bubble: r1 first so the pointer favours r2 next
    reset_dut();
    set_req(1, 1'b1, 1'b0, 16'h3c00, 16'h3c00, 16'hffff, 10'h1);
    tick(1);
    set_req(0, 1'b1, 1'b0, 16'h4000, 16'h4000, 16'hffff, 10'h10);
    set_req(2, 1'b1, 1'b1, 16'h4200, 16'h4200, 16'hffff, 10'h20);
    tick(1);
    req_valid[2] = 1'b0;
    tick(1);
    req_valid[2] = 1'b1;
    tick(2);
    req_valid[2] = 1'b0;
    req_lock[2] = 1'b0;
    tick(1);
    req_valid = '0;
    tick(10);
    begin
      int lid[5] = '{1, 2, 2, 2, 0};
      int loff[5] = '{0, 1, 3, 4, 5};
      chk("lock_grants", 256'(gq.size()), 256'(5));
      for (int i = 0; i < 5; i++) begin
        chk("lock_grant_id", 256'(gq[i].id), 256'(lid[i]));
        chk("lock_grant_cyc", 256'(gq[i].due - gq[0].due), 256'(loff[i]));
      end
    end

    // table vectors, one per cycle from r0
    reset_dut();
    for (int i = 0; i < 13; i++) begin
      set_req(0, 1'b1, 1'b0, tbl[i].a, tbl[i].b, tbl[i].en, 10'(i));
      tick(1);
    end
    req_valid = '0;
    tick(10);
    chk("tbl_rsps", 256'(rq.size()), 256'(13));
    for (int i = 0; i < 13; i++) begin
      logic [255:0] x;
      for (int k = 0; k < LANES; k++) x[k*16 +: 16] = tbl[i].en[k] ? tbl[i].p : 16'h0;
      chk("tbl_data", rq[i].data, x);
      chk("tbl_lane_en", 256'(rq[i].en), 256'(tbl[i].en));
      chk("tbl_tag", 256'(rq[i].tag), 256'(i));
    end

    // randomized traffic with occasional locks
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        req_valid[r] = ($urandom % 4) != 0;
        req_lock[r] = ($urandom % 6) == 0;
        req_tag[r*TW +: TW] = 10'($urandom);
        req_lane_en[r*LANES +: LANES] = ($urandom % 3 == 0) ? 16'($urandom) : 16'hffff;
        for (int k = 0; k < LANES; k++) begin
          req_a[(r*LANES+k)*DW +: DW] = 16'($urandom);
          req_b[(r*LANES+k)*DW +: DW] = ($urandom % 4 == 0) ? 16'h3c00 : 16'($urandom);
        end
      end
      tick(1);
    end
    req_valid = '0;
    req_lock = '0;
    tick(12);
    chk("rand_drain", 256'(q.size()), 256'(0));

    // reset in the middle of four issues
    reset_dut();
    set_req(0, 1'b1, 1'b0, 16'h4000, 16'h4000, 16'hffff, 10'h33);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req_valid = '0;
    rq.delete();
    tick(10);
    chk("midflight_no_rsp", 256'(rq.size()), 256'(0));
    chk("midflight_err", 256'(err), 256'(0));

    // fault: lane 0 valid_out high with empty pipe, after WARM
    force dut.lane0_vout = 1'b1;
    tick(1);
    release dut.lane0_vout;
    exp_err = 1'b1;
    chk("fault_err_set", 256'(err), 256'(1));
    tick(5);
    chk("fault_err_sticky", 256'(err), 256'(1));
    reset_dut();
    chk("fault_err_cleared", 256'(err), 256'(0));
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp16_mul_arbiter.md
# fp16_mul_arbiter

Shared pipelined FP16 multiplier array for the Mamba-2 SSD step datapath. Up to NREQ stage controllers (for example the dBx, hC and y·D sequencers) issue LANES-wide element-wise multiply operations. This block grants one requester per cycle (round-robin, with optional burst lock), feeds the LANES `fp16_mult_wrapper` instances it owns, and routes each result back to its issuer with the issuer's tag. It replaces the private multiplier banks inside each stage controller.

## Interface
- `NREQ`, 3, number of requesters (2..8)
- `LANES`, 16, multiplier lanes per operation
- `DW`, 16, element width (FP16)
- `TW`, 10, requester-defined tag width (flattened element index)
- `M_LAT`, 6, latency of `fp16_mult_wrapper` from valid_in to valid_out
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  operation request, one bit per requester
- `req_ready`  out  NREQ  grant; the handshake completes when valid and ready are both high
- `req_lock`  in  NREQ  requester keeps ownership across cycles while high
- `req_a`, `req_b`  in  NREQ*LANES*DW  operands; requester r, lane k at `[(r*LANES+k+1)*DW-1 -: DW]`
- `req_lane_en`  in  NREQ*LANES  per-lane enable, used for a partial final chunk
- `req_tag`  in  NREQ*TW  opaque tag returned with the result
- `rsp_valid`  out  NREQ  one-hot; result belongs to requester r
- `rsp_data`  out  LANES*DW  products; disabled lanes read 0
- `rsp_lane_en`  out  LANES  lane enables echoed from the request
- `rsp_tag`  out  TW  tag echoed from the request
- `busy`  out  1  high while any operation is in flight
- `err`  out  1  sticky tag/valid misalignment flag; cleared only by `rst`

## Operation
- Arbitration is round-robin. The search starts at `(last_owner+1) mod NREQ`. At most one `req_ready` bit is high per cycle, and only for a requester whose `req_valid` is high. `req_ready` is combinational from `req_valid`, `req_lock`, the owner register and the pointer.
- Lock:
  - If the previous cycle's owner has `req_lock=1`, it remains owner and every other requester is held off.
  - This holds even in cycles where the owner has `req_valid=0`. Those cycles are bubbles and issue nothing.
  - Ownership is released in the first cycle the owner has `req_lock=0`. In that same cycle arbitration proceeds normally from `owner+1`.
- Issue: on a handshake the block registers the granted operands into the lane input registers. Lanes with `lane_en=0` are loaded with 0.
  - `valid_in` to the wrappers is high for one cycle per handshake.
  - A tracking shift register of depth `M_LAT+1` records `{valid, owner id, tag, lane_en}` alongside each operation.
- Retire: when the tracking register's tail entry is valid, the block drives `rsp_valid[owner]=1` with `rsp_tag`, `rsp_lane_en` and lane-masked `rsp_data`. Responses have no backpressure; requesters must accept them in the cycle presented.
- Check: `err` is set if lane 0 `valid_out` differs from the tail `valid` bit. The check is masked for `M_LAT+1` cycles after `rst` deasserts, because the wrappers have no reset.
- `busy` = OR of all tracking-register valid bits.
- States:
  - RUN: normal operation.
  - WARM: entered on `rst`. Lasts `M_LAT+1` cycles, counted by a down-counter. Arbitration and issue are enabled; only the err check is masked. Transitions to RUN afterwards.

## Timing
- Reset values:
  - `rsp_valid=0`, `rsp_data=0`, `rsp_tag=0`, `rsp_lane_en=0`, `busy=0`, `err=0`.
  - Round-robin pointer = NREQ-1, so requester 0 wins first. No owner and no lock.
  - Tracking register cleared.
- `req_ready` may be high in the first cycle after `rst` deasserts.
- Latency: a handshake in cycle t gives a response in cycle t+M_LAT+1 (7 with defaults), registered.
- Throughput: one operation per cycle sustained, with no dead cycles between different owners.
- Reset mid-operation discards all in-flight operations. No `rsp_valid` pulse is produced for them afterwards, even though stale wrapper outputs emerge.
- Response ordering equals issue order across all requesters.

## Test plan
- Reset then a single request: r1 issues a=2.0 (0x4000) and b=3.0 (0x4200) on all lanes, tag=0x05A, handshake in cycle 0. Required: `rsp_valid=3'b010` in cycle 7 only, every lane 0x4600, `rsp_tag=0x05A`; `busy` high for cycles 1–7.
- Fairness: all three requesters hold `req_valid` continuously for 9 cycles, no lock. Required: grant order 0,1,2,0,1,2,0,1,2, and responses return one per cycle in the same order starting 7 cycles after the first grant.
- Lock with bubble: r2 holds lock for 4 cycles with valid low in the 2nd cycle; r0 and r1 request throughout. Required: r2 granted in cycles 0, 2 and 3; no grant in cycle 1; r0 granted in cycle 4, the first cycle after r2's lock is released.
- Partial chunk: `lane_en=16'h000F` with operands 1.0×1.0. Required: lanes 0–3 are 0x3C00, lanes 4–15 are 0x0000, `rsp_lane_en=16'h000F`.
- Reset mid-flight: issue 4 operations, assert `rst` for 1 cycle at cycle 3. Required: no `rsp_valid` for at least 7 cycles after reset, and `err` stays 0.
- Fault injection: force lane 0 `valid_out` high with the pipeline empty after WARM has ended. Required: `err=1` the next cycle, remaining 1 until `rst`.
